// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered execution unit for the datapath.
//
// Purpose:
//   This is the registered successor to the 4-bit combinational ALU. It is
//   parametrised and keeps the same eight operations (four logic, four
//   arithmetic) and the Z/C/S flags. It adds the following:
//     - a result/flag accumulator (R, RH, z, c, s) that holds its value
//       between operations;
//     - a start/busy/done handshake;
//     - operand chaining, where operand A is taken from the current R;
//     - an iterative shift-add unsigned multiply. It performs one step per
//       cycle and produces a 2*WIDTH-bit product in {RH,R}.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 2)
//   CNTW    multiply iteration counter width (derived from WIDTH)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   start    in   launch an operation (sampled only while busy=0)
//   arit     in   0 = logic group, 1 = arithmetic group
//   Op       in   operation select within the group
//   mul      in   1 = unsigned multiply (overrides arit/Op)
//   acc_sel  in   1 = operand A comes from the R register
//   A, B     in   operands
//   R        out  result register (low half of the product for mul)
//   RH       out  high half of the product; 0 after non-mul ops
//   z, c, s  out  zero / carry / sign flags
//   busy     out  multiply in progress
//   done     out  one-cycle pulse: R/RH/flags just updated
//   v        out  signed overflow flag (only when ALU_OVERFLOW_EN is defined)
//
// Optional feature:
//   Defining the macro ALU_OVERFLOW_EN adds the v port. The v port gives
//   two's-complement overflow for the arithmetic group. It is 0 for logic
//   operations and for mul.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             arit,
  input  logic [1:0]       Op,
  input  logic             mul,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] RH,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             busy,
  output logic             done
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             v
`endif
);

  localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_LOAD = CNTW'(WIDTH);
  // The counter value that decrements to 1, ending the MUL phase.
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state;
  logic [CNTW-1:0]     cnt;
  logic [WIDTH-1:0]    mcand_p1;
  logic [2*WIDTH-1:0]  prod_p1;

  logic [WIDTH-1:0]    a_op;
  logic [WIDTH:0]      alu_res;
  logic [2*WIDTH-1:0]  prod_next;
  logic                launch;
  logic                launch_mul;

  // -------------------------------------------------------------------------
  // Single-cycle ALU. The result is WIDTH+1 bits and bit WIDTH is the carry.
  // Subtraction and negation use the "+1 inversion" form. As a result,
  // A-B with A>=B gives carry=1, and negating 0 also gives carry=1.
  // -------------------------------------------------------------------------
  function automatic logic [WIDTH:0] alu_calc(
    input logic             ar,
    input logic [1:0]       op_sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] res;
    a_x = {1'b0, a};
    b_x = {1'b0, b};
    res = '0;
    if (!ar) begin
      unique case (op_sel)
        2'b00:   res = a_x & b_x;
        2'b01:   res = a_x | b_x;
        2'b10:   res = a_x ^ b_x;
        default: res = {1'b0, ~a};
      endcase
    end else begin
      unique case (op_sel)
        2'b00:   res = a_x + b_x;
        2'b01:   res = a_x + {1'b0, ~b} + ONE_X;
        2'b10:   res = {1'b0, ~a} + ONE_X;
        default: res = {1'b0, ~b} + ONE_X;
      endcase
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // One shift-add multiply step.
  //
  // The product register starts as {0, multiplier}. On each step, the
  // multiplicand is added into the high half when the current low bit is 1.
  // The whole register is then shifted right by one. The carry of the
  // addition enters at the top, so after WIDTH steps the register holds
  // the full product.
  // -------------------------------------------------------------------------
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] prod,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] hi;
    hi = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) begin
      hi = hi + {1'b0, mcand};
    end
    return {hi, prod[WIDTH-1:1]};
  endfunction

`ifdef ALU_OVERFLOW_EN
  // Signed overflow of the arithmetic group.
  // This is decided from sign bits only.
  function automatic logic ovf_calc(
    input logic             ar,
    input logic [1:0]       op_sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r
  );
    logic [WIDTH-1:0] min_neg;
    logic             ovf;
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    ovf     = 1'b0;
    if (ar) begin
      unique case (op_sel)
        2'b00:   ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        2'b01:   ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        2'b10:   ovf = (a == min_neg);
        default: ovf = (b == min_neg);
      endcase
    end
    return ovf;
  endfunction
`endif

  // Operand selection and combinational results, used at the launch edge
  // and by the final multiply step.
  always_comb begin
    a_op       = acc_sel ? R : A;
    alu_res    = alu_calc(arit, Op, a_op, B);
    prod_next  = mul_step(prod_p1, mcand_p1);
    launch     = (state == IDLE) && start;
    launch_mul = launch && mul;
  end

  // ---- stage p1: multiplier data registers ----
  // These registers are only meaningful while in MUL/FIN. They are reloaded
  // at every multiply launch, so they need no reset.
  always_ff @(posedge clk) begin
    if (launch_mul) begin
      mcand_p1 <= a_op;
      prod_p1  <= {{WIDTH{1'b0}}, B};
    end else if (state == MUL) begin
      prod_p1  <= prod_next;
    end
  end

  // ---- stage p1: control FSM and architectural result/flag registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      R     <= '0;
      RH    <= '0;
      z     <= 1'b1;
      c     <= 1'b0;
      s     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      v     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch_mul) begin
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
            state <= MUL;
          end else if (launch) begin
            R    <= alu_res[WIDTH-1:0];
            RH   <= '0;
            z    <= (alu_res[WIDTH-1:0] == '0);
            // The logic group defines c and s as 0, even though the result
            // MSB may be set.
            c    <= arit & alu_res[WIDTH];
            s    <= arit & alu_res[WIDTH-1];
            done <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            v    <= ovf_calc(arit, Op, a_op, B, alu_res[WIDTH-1:0]);
`endif
          end
        end

        MUL: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= FIN;
          end
        end

        FIN: begin
          // The final step is taken here, and the product is written in
          // the same edge.
          R     <= prod_next[WIDTH-1:0];
          RH    <= prod_next[2*WIDTH-1:WIDTH];
          z     <= (prod_next == '0);
          c     <= |prod_next[2*WIDTH-1:WIDTH];
          s     <= prod_next[2*WIDTH-1];
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
`ifdef ALU_OVERFLOW_EN
          v     <= 1'b0;
`endif
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It keeps the same 8-operation set (4 logic, 4 arithmetic) and Z/C/S flags, and adds:
- a registered result/flag accumulator;
- a start/busy/done handshake;
- an operand-chaining mode (A taken from the previous result);
- an iterative shift-add unsigned multiply.

It sits in the datapath as the execution unit driven by the control FSM.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNTW, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only when busy=0
arit  input  1  0=logic group, 1=arithmetic group
Op  input  2  operation select within group
mul  input  1  1=multiply (overrides arit/Op)
acc_sel  input  1  1=operand A taken from current R register instead of A
A  input  WIDTH  operand A
B  input  WIDTH  operand B
R  output  WIDTH  result register (low half of product for mul)
RH  output  WIDTH  high half of product; 0 after non-mul ops
z  output  1  zero flag
c  output  1  carry flag
s  output  1  sign flag
busy  output  1  multiply in progress
done  output  1  one-cycle pulse, result/flags valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port reset.
- Reset: R, RH, counter = 0; z=1; c, s, busy, done = 0; FSM -> IDLE.
- Effective A: Aop = acc_sel ? R : A, sampled at the start edge.
- FSM states: IDLE, MUL, FIN.
- IDLE:
  - start=1, mul=0 -> compute combinationally and register R/flags on that edge; done=1 next cycle; stay IDLE. Latency is 1 cycle.
  - start=1, mul=1 -> load multiplicand/multiplier, clear product, counter=WIDTH; go to MUL; busy=1.
- MUL: one shift-add step per cycle. Counter decrements; when it reaches 1, go to FIN.
- FIN: write {RH,R} = Aop*B and update flags; done=1 for one cycle; busy=0; return to IDLE. Total latency: done asserted exactly WIDTH+1 cycles after the start edge.
- start while busy=1: ignored, with no effect on the in-flight operation.
- Logic ops (arit=0):
  - 00: Aop&B
  - 01: Aop|B
  - 10: Aop^B
  - 11: ~Aop
  - c=0, s=0 (defined; no x).
- Arithmetic ops (arit=1), computed in WIDTH+1 bits:
  - 00: Aop+B
  - 01: Aop+(~B+1)
  - 10: ~Aop+1
  - 11: ~B+1
  - c = bit WIDTH; s = bit WIDTH-1.
  - The same +1 inversion rule as the existing ALU applies, so A-B with A>=B gives c=1, and negating 0 gives c=1.
- Flags:
  - z = (R==0) for non-mul ops; z = ({RH,R}==0) for mul.
  - mul: c = (RH!=0); s = RH[WIDTH-1].
- RH is cleared on every non-mul completion.
- R/RH/flags hold their value between operations. done is low except for its single-cycle pulse.
- reset during MUL: aborts immediately; all outputs take reset values; no done pulse.
- start and reset in the same cycle: reset wins.

Optional Feature:
ALU_OVERFLOW_EN
- Defined:
  - adds output port v (1 bit, reset 0) = signed two's-complement overflow.
  - Op 00: operands' sign bits equal and result sign differs.
  - Op 01: operand signs differ and result sign differs from Aop.
  - Op 10: Aop==100..0.
  - Op 11: B==100..0.
  - v=0 for logic and mul.
- Undefined: no v port; all other behaviour identical.

Test Plan:
- WIDTH=8, start with arit=1 Op=00 A=0xF0 B=0x20 -> next cycle done=1, R=0x10, c=1, s=0, z=0, RH=0.
- arit=1 Op=01 A=0x05 B=0x05 -> R=0x00, z=1, c=1, s=0. Then arit=0 Op=11 A=0x0F -> R=0xF0, c=0, s=0, z=0.
- mul=1 A=0xFF B=0xFF -> busy=1 for cycles 1..8; done on cycle 9 (WIDTH+1); R=0x01, RH=0xFE, c=1, s=1, z=0. A start pulse with A=1 B=1 at cycle 4 is ignored.
- Chain: add A=0x03 B=0x04 (R=0x07), then acc_sel=1 arit=1 Op=00 B=0x01 -> R=0x08. Then acc_sel=1 mul=1 B=0x02 -> R=0x10, RH=0.
- reset asserted at cycle 3 of a multiply -> next cycle R=0, RH=0, z=1, busy=0; no done pulse; a new start then completes normally.
- ALU_OVERFLOW_EN defined: Op=00 A=0x7F B=0x01 -> R=0x80, v=1, s=1, c=0. Op=10 A=0x80 -> R=0x80, v=1. Op=00 A=0x01 B=0x01 -> v=0.
